// File: rtl/if_id_fetch_stage_pkg.sv
// Shared pipeline constants: reset PC, PC step, NOP encoding, fetch alignment mask.
package if_id_fetch_stage_pkg;

    localparam int unsigned XLEN           = 32;
    localparam logic [XLEN-1:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam int unsigned DEF_PC_STEP    = 4;
    localparam logic [XLEN-1:0] DEF_NOP_INSTR = 32'h0000_0000;
    // Clears the byte-offset bits below one PC step.
    localparam logic [XLEN-1:0] DEF_ALIGN_MASK = ~XLEN'(DEF_PC_STEP - 1);

endpackage

// File: rtl/if_id_fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls in, imem port, IF/ID register and statistics out.
interface if_id_fetch_stage_if #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH   = 16
);
    logic                   pc_load;
    logic                   IF_ID_load;
    logic                   redirect;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_data;
    logic [INSTR_WIDTH-1:0] IF_ID_instr;
    logic [PC_WIDTH-1:0]    IF_ID_pc_next;
    logic                   IF_ID_valid;
    logic [CNT_WIDTH-1:0]   stall_cycles;
    logic [CNT_WIDTH-1:0]   flush_count;
    logic                   ld_mismatch;

    // Fetch stage side.
    modport master (
        input  pc_load, IF_ID_load, redirect, redirect_pc, imem_data,
        output imem_addr, IF_ID_instr, IF_ID_pc_next, IF_ID_valid,
               stall_cycles, flush_count, ld_mismatch
    );

    // Hazard unit / EX / instruction memory side.
    modport slave (
        output pc_load, IF_ID_load, redirect, redirect_pc, imem_data,
        input  imem_addr, IF_ID_instr, IF_ID_pc_next, IF_ID_valid,
               stall_cycles, flush_count, ld_mismatch
    );
endinterface

// File: rtl/if_id_fetch_stage_sat_counter.sv
// Saturating up-counter with synchronous clear.
module if_id_fetch_stage_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);
    logic [WIDTH-1:0] r_count;

    // Count enabled cycles, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/if_id_fetch_stage.sv
// Fetch stage: PC register, imem addressing, IF/ID capture with flush bubbles, stall/flush stats.
module if_id_fetch_stage
    import if_id_fetch_stage_pkg::*;
#(
    parameter int unsigned            PC_WIDTH    = 32,
    parameter int unsigned            INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = PC_WIDTH'(DEF_RESET_PC),
    parameter int unsigned            PC_STEP     = DEF_PC_STEP,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(DEF_NOP_INSTR),
    parameter int unsigned            CNT_WIDTH   = 16
) (
    input  logic                clk,
    input  logic                rst,
    if_id_fetch_stage_if.master bus
);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(PC_STEP - 1);

    logic [PC_WIDTH-1:0]    r_pc;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [PC_WIDTH-1:0]    r_pc_next;
    logic                   r_valid;
    logic                   r_mismatch;

    logic [PC_WIDTH-1:0]    w_pc_inc;
    logic                   w_stall_en;
    logic                   w_flush_en;

    assign w_pc_inc   = r_pc + PC_WIDTH'(PC_STEP);
    // A stall coinciding with a redirect is on the wrong path and is not counted.
    assign w_stall_en = !bus.redirect && !bus.IF_ID_load;
    assign w_flush_en = bus.redirect;

    // PC and IF/ID update: redirect flushes, otherwise each load is honoured independently.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_instr    <= NOP_INSTR;
            r_pc_next  <= '0;
            r_valid    <= 1'b0;
            r_mismatch <= 1'b0;
        end else if (bus.redirect) begin
            r_pc    <= bus.redirect_pc & ALIGN_MASK;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else begin
            if (bus.pc_load) begin
                r_pc <= w_pc_inc;
            end
            if (bus.IF_ID_load) begin
                r_instr   <= bus.imem_data;
                r_pc_next <= w_pc_inc;
                r_valid   <= 1'b1;
            end
            if (bus.pc_load != bus.IF_ID_load) begin
                r_mismatch <= 1'b1;
            end
        end
    end

    if_id_fetch_stage_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_stall_en),
        .o_count (bus.stall_cycles)
    );

    if_id_fetch_stage_sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_flush_en),
        .o_count (bus.flush_count)
    );

    assign bus.imem_addr     = r_pc;
    assign bus.IF_ID_instr   = r_instr;
    assign bus.IF_ID_pc_next = r_pc_next;
    assign bus.IF_ID_valid   = r_valid;
    assign bus.ld_mismatch   = r_mismatch;
endmodule
